// File: rtl/wb_stage.sv
// Purpose : MEM/WB pipeline register, load-data formatter, regfile write port driver,
//           same-cycle write->read bypass to ID, and retired-instruction counter.
// Latency : instruction captured at posedge N is written (WE/W_addr/W_data) during cycle N+1.
// Backpr. : hold freezes the stage and suppresses WE; flush kills the entering instruction.
//
// Ports
//   clk            core clock, all state on rising edge
//   rst            asynchronous active-low reset
//   mem_valid      MEM holds a real instruction
//   mem_reg_we     instruction writes a GPR
//   mem_wr_addr    destination GPR
//   mem_to_reg     1: result is load data, 0: ALU result
//   mem_load_type  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others LW
//   mem_alu_result ALU result / effective address ([1:0] = byte offset)
//   mem_rdata      raw aligned word from data memory
//   hold           WB frozen (downstream stall)
//   flush          kill instruction entering WB
//   rf_addr_a/_b   ID read addresses
//   rf_data_a/_b   regfile read data
//   WE/W_addr/W_data  regfile write port
//   id_data_a/_b   bypassed read data to ID
//   retire_cnt     retired-instruction count (wraps)

module wb_stage #(
    parameter int CNT_W      = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_reg_we,
    input  logic [4:0]       mem_wr_addr,
    input  logic             mem_to_reg,
    input  logic [2:0]       mem_load_type,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_rdata,
    input  logic             hold,
    input  logic             flush,
    input  logic [4:0]       rf_addr_a,
    input  logic [4:0]       rf_addr_b,
    input  logic [31:0]      rf_data_a,
    input  logic [31:0]      rf_data_b,
    output logic             WE,
    output logic [4:0]       W_addr,
    output logic [31:0]      W_data,
    output logic [31:0]      id_data_a,
    output logic [31:0]      id_data_b,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    // Captured MEM/WB fields
    logic             r_valid;
    logic             r_reg_we;
    logic [4:0]       r_wr_addr;
    logic             r_mem_to_reg;
    logic [2:0]       r_load_type;
    logic [31:0]      r_alu_result;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_retire_cnt;

    // Formatter intermediates
    logic [1:0]       w_offset;
    logic [1:0]       w_lane;
    logic             w_hsel;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_wdata;
    logic             w_we;

    // ------------------------------------------------------------------
    // Pipeline register: flush beats hold beats normal capture.
    // Only valid is cleared on flush; the other fields are don't-care then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_reg_we     <= 1'b0;
            r_wr_addr    <= 5'd0;
            r_mem_to_reg <= 1'b0;
            r_load_type  <= 3'd0;
            r_alu_result <= 32'd0;
            r_rdata      <= 32'd0;
        end else if (flush) begin
            r_valid      <= 1'b0;
        end else if (!hold) begin
            r_valid      <= mem_valid;
            r_reg_we     <= mem_reg_we;
            r_wr_addr    <= mem_wr_addr;
            r_mem_to_reg <= mem_to_reg;
            r_load_type  <= mem_load_type;
            r_alu_result <= mem_alu_result;
            r_rdata      <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Retire counter: the instruction in WB retires in any cycle it is not
    // held, whether or not it writes a register. Wraps naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !hold) begin
            r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Load alignment. For big-endian, byte 0 lives in [31:24], so the
    // physical lane is the inverted offset; the same holds for halfwords.
    // ------------------------------------------------------------------
    always_comb begin
        w_offset = r_alu_result[1:0];
        w_lane   = BIG_ENDIAN ? ~w_offset : w_offset;
        w_hsel   = BIG_ENDIAN ? ~w_offset[1] : w_offset[1];

        w_byte = 8'h00;
        unique case (w_lane)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase

        w_half = w_hsel ? r_rdata[31:16] : r_rdata[15:0];

        w_load = r_rdata;
        case (r_load_type)
            LT_LH:   w_load = {{16{w_half[15]}}, w_half};
            LT_LHU:  w_load = {16'h0000, w_half};
            LT_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  w_load = {24'h000000, w_byte};
            LT_LW:   w_load = r_rdata;
            default: w_load = r_rdata;  // reserved encodings behave as LW
        endcase

        w_wdata = r_mem_to_reg ? w_load : r_alu_result;
    end

    // $0 is never written, and a held instruction writes only once hold drops.
    assign w_we = r_valid & r_reg_we & (r_wr_addr != 5'd0) & ~hold;

    assign WE         = w_we;
    assign W_addr     = r_wr_addr;
    assign W_data     = w_wdata;
    assign retire_cnt = r_retire_cnt;

    // Regfile reads the old value in the write cycle; forward the new one.
    // Gating by WE keeps $0 and held/invalid slots out of the bypass.
    assign id_data_a = (w_we && (rf_addr_a == r_wr_addr)) ? w_wdata : rf_data_a;
    assign id_data_b = (w_we && (rf_addr_b == r_wr_addr)) ? w_wdata : rf_data_b;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_we;
    logic [4:0]  mem_wr_addr;
    logic        mem_to_reg;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rdata;
    logic        hold;
    logic        flush;
    logic [4:0]  rf_addr_a;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;

    logic        we_le;
    logic [4:0]  waddr_le;
    logic [31:0] wdata_le;
    logic [31:0] ida_le;
    logic [31:0] idb_le;
    logic [31:0] cnt_le;

    logic        we_be;
    logic [4:0]  waddr_be;
    logic [31:0] wdata_be;
    logic [31:0] ida_be;
    logic [31:0] idb_be;
    logic [3:0]  cnt_be;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage #(.CNT_W(32), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_wr_addr(mem_wr_addr),
        .mem_to_reg(mem_to_reg), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .hold(hold), .flush(flush),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .WE(we_le), .W_addr(waddr_le), .W_data(wdata_le),
        .id_data_a(ida_le), .id_data_b(idb_le), .retire_cnt(cnt_le)
    );

    wb_stage #(.CNT_W(4), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_wr_addr(mem_wr_addr),
        .mem_to_reg(mem_to_reg), .mem_load_type(mem_load_type),
        .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .hold(hold), .flush(flush),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .WE(we_be), .W_addr(waddr_be), .W_data(wdata_be),
        .id_data_a(ida_be), .id_data_b(idb_be), .retire_cnt(cnt_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Present one instruction to MEM for a single capture edge, then bubble.
    task automatic issue(input logic we, input logic [4:0] addr, input logic m2r,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rd);
        mem_valid      = 1'b1;
        mem_reg_we     = we;
        mem_wr_addr    = addr;
        mem_to_reg     = m2r;
        mem_load_type  = lt;
        mem_alu_result = alu;
        mem_rdata      = rd;
        tick();
        mem_valid      = 1'b0;
    endtask

    logic [2:0]  lv_type [6];
    logic [1:0]  lv_off  [6];
    logic [31:0] lv_exp  [6];

    initial begin
        lv_type[0] = 3'b011; lv_off[0] = 2'd3; lv_exp[0] = 32'hFFFFFF80;
        lv_type[1] = 3'b100; lv_off[1] = 2'd3; lv_exp[1] = 32'h00000080;
        lv_type[2] = 3'b001; lv_off[2] = 2'd2; lv_exp[2] = 32'hFFFF80F1;
        lv_type[3] = 3'b010; lv_off[3] = 2'd0; lv_exp[3] = 32'h00007F02;
        lv_type[4] = 3'b111; lv_off[4] = 2'd1; lv_exp[4] = 32'h80F17F02;
        lv_type[5] = 3'b011; lv_off[5] = 2'd0; lv_exp[5] = 32'h00000002;

        // Reset with MEM inputs active
        rst = 1'b0; hold = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_reg_we = 1'b1; mem_wr_addr = 5'd5; mem_to_reg = 1'b0;
        mem_load_type = 3'd0; mem_alu_result = 32'h1234; mem_rdata = 32'h0;
        rf_addr_a = 5'd0; rf_addr_b = 5'd0; rf_data_a = 32'h11; rf_data_b = 32'h22;
        tick(); tick();
        check("rst_we", {31'd0, we_le}, 32'd0);
        check("rst_cnt", cnt_le, 32'd0);
        check("rst_waddr", {27'd0, waddr_le}, 32'd0);
        check("rst_wdata", wdata_le, 32'd0);
        check("rst_ida", ida_le, 32'h11);
        rst = 1'b1;

        // First ALU op after reset release
        issue(1'b1, 5'd5, 1'b0, 3'd0, 32'h1234, 32'h0);
        check("alu_we", {31'd0, we_le}, 32'd1);
        check("alu_waddr", {27'd0, waddr_le}, 32'd5);
        check("alu_wdata", wdata_le, 32'h1234);
        check("alu_cnt_pre", cnt_le, 32'd0);
        tick();
        check("alu_cnt_post", cnt_le, 32'd1);

        // Load formatting
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 5'd3, 1'b1, lv_type[i], {30'd0, lv_off[i]}, 32'h80F17F02);
            check($sformatf("load%0d", i), wdata_le, lv_exp[i]);
        end
        check("be_lb_off0", wdata_be, 32'hFFFFFF80);

        // $0 guard
        apply_reset();
        rf_addr_a = 5'd0; rf_data_a = 32'h5A5A;
        issue(1'b1, 5'd0, 1'b0, 3'd0, 32'hDEAD, 32'h0);
        check("r0_we", {31'd0, we_le}, 32'd0);
        check("r0_ida", ida_le, 32'h5A5A);
        tick();
        check("r0_cnt", cnt_le, 32'd1);

        // Bypass
        rf_addr_a = 5'd7; rf_addr_b = 5'd7; rf_data_a = 32'h0; rf_data_b = 32'h0;
        issue(1'b1, 5'd7, 1'b0, 3'd0, 32'hAAAA5555, 32'h0);
        check("byp_a", ida_le, 32'hAAAA5555);
        check("byp_b", idb_le, 32'hAAAA5555);
        rf_addr_a = 5'd8; rf_data_a = 32'h1357;
        #1;
        check("byp_a_miss", ida_le, 32'h1357);
        check("byp_b_keep", idb_le, 32'hAAAA5555);

        // Hold
        apply_reset();
        issue(1'b1, 5'd9, 1'b0, 3'd0, 32'h99, 32'h0);
        hold = 1'b1;
        mem_valid = 1'b1; mem_wr_addr = 5'd10; mem_alu_result = 32'hCC;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d_we", i), {31'd0, we_le}, 32'd0);
            tick();
            check($sformatf("hold%0d_waddr", i), {27'd0, waddr_le}, 32'd9);
            check($sformatf("hold%0d_wdata", i), wdata_le, 32'h99);
            check($sformatf("hold%0d_cnt", i), cnt_le, 32'd0);
        end
        hold = 1'b0; mem_valid = 1'b0;
        #1;
        check("unhold_we", {31'd0, we_le}, 32'd1);
        check("unhold_waddr", {27'd0, waddr_le}, 32'd9);
        tick();
        check("unhold_cnt", cnt_le, 32'd1);
        check("unhold_we_off", {31'd0, we_le}, 32'd0);

        // Flush beats hold
        issue(1'b1, 5'd11, 1'b0, 3'd0, 32'hBB, 32'h0);
        hold = 1'b1; flush = 1'b1;
        mem_valid = 1'b1; mem_wr_addr = 5'd12;
        tick();
        hold = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        #1;
        check("flush_we", {31'd0, we_le}, 32'd0);
        check("flush_cnt", cnt_le, 32'd1);
        tick();
        check("flush_cnt2", cnt_le, 32'd1);

        // Counter wrap on the CNT_W=4 instance
        apply_reset();
        mem_valid = 1'b1; mem_reg_we = 1'b1; mem_wr_addr = 5'd1; mem_to_reg = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        mem_valid = 1'b0;
        tick();
        check("wrap_cnt32", cnt_le, 32'd17);
        check("wrap_cnt4", {28'd0, cnt_be}, 32'd1);

        // Async reset: WE drops immediately, held instruction discarded
        issue(1'b1, 5'd9, 1'b0, 3'd0, 32'h77, 32'h0);
        check("ar_we_pre", {31'd0, we_le}, 32'd1);
        hold = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("ar_waddr", {27'd0, waddr_le}, 32'd0);
        check("ar_cnt", cnt_le, 32'd0);
        rst = 1'b1; hold = 1'b0;
        #1;
        check("ar_we_post", {31'd0, we_le}, 32'd0);
        tick();
        check("ar_cnt_post", cnt_le, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
